// File: rtl/serial_frame_rx.sv
// Asynchronous serial frame receiver: start bit, LSB-first data, optional even parity, stop bit.
// Samples each bit at mid-bit using a per-bit cycle counter on the synchronized line.
module serial_frame_rx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e            state;
  logic              d_meta;
  logic              ds;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic              par;
  // Blocks start detection until the line has been seen idle after reset.
  logic              armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_meta     <= 1'b1;
      ds         <= 1'b1;
      state      <= StIdle;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      armed      <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      d_meta <= d;
      ds     <= d_meta;
      valid  <= 1'b0;

      unique case (state)
        StIdle: begin
          cnt <= '0;
          if (ds) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= StStart;
            busy  <= 1'b1;
          end
        end

        StStart: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (ds) begin
              // False start: the line went back high before mid-bit.
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              state <= StData;
              idx   <= '0;
              par   <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StData: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {ds, shreg[DATA_W-1:1]};
            par   <= par ^ ds;
            if (idx == IDX_LAST) begin
              state <= (PARITY_EN != 0) ? StParity : StStop;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StParity: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            par   <= par ^ ds;
            state <= StStop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StStop: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            valid      <= 1'b1;
            data_out   <= shreg;
            parity_err <= (PARITY_EN != 0) && par;
            frame_err  <= ~ds;
            if (ds) begin
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              state <= StBreak;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StBreak: begin
          if (ds) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus a random frame stream, checked every cycle
// against a frame-level model (expected valid cycle, data word and error flags per frame).
module tb_serial_frame_rx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int PE  = 1;
  // Cycles from the first clock edge after d falls to the cycle valid is high.
  localparam int LAT = 2 + CPB / 2 + (DW + PE + 1) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          d = 1'b1;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  serial_frame_rx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (PE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .data_out  (data_out),
    .valid     (valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct {
    int          cyc;
    logic [DW-1:0] data;
    logic        pe;
    logic        fe;
  } exp_t;

  exp_t          q[$];
  exp_t          ce;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            valid_count = 0;
  int            last_valid_cyc = -1;
  logic [DW-1:0] m_data = '0;
  logic          m_pe = 1'b0;
  logic          m_fe = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame-level reference: valid must appear at the frame's predicted cycle (+/-1), and the
  // registered outputs must equal the last accepted frame's values at all times.
  always @(negedge clk) begin
    if (!rst) begin
      m_data = '0;
      m_pe   = 1'b0;
      m_fe   = 1'b0;
      chk("valid_in_reset", 32'(valid), 32'd0);
    end else if (valid) begin
      valid_count++;
      last_valid_cyc = cyc;
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        ce = q.pop_front();
        checks++;
        if (cyc < ce.cyc - 1 || cyc > ce.cyc + 1) begin
          failures++;
          $display("FAIL valid_latency: got cycle %0d required %0d", cyc, ce.cyc);
        end
        m_data = ce.data;
        m_pe   = ce.pe;
        m_fe   = ce.fe;
      end
    end else if (q.size() != 0 && cyc > q[0].cyc + 1) begin
      chk("missing_valid", 32'(valid), 32'd1);
      void'(q.pop_front());
    end
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("parity_err", 32'(parity_err), 32'(m_pe));
    chk("frame_err", 32'(frame_err), 32'(m_fe));
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    d = b;
    wait_cycles(n);
  endtask

  task automatic send_frame(input logic [DW-1:0] dat, input logic pbit, input logic sbit,
                            input int extra_low, output int fall);
    exp_t e;
    fall   = cyc;
    e.cyc  = cyc + 1 + LAT;
    e.data = dat;
    e.pe   = (^dat) ^ pbit;
    e.fe   = ~sbit;
    q.push_back(e);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DW; i++) drive_bit(dat[i], CPB);
    drive_bit(pbit, CPB);
    drive_bit(sbit, CPB + (sbit ? 0 : extra_low));
    if (!sbit) chk("break_busy", 32'(busy), 32'd1);
    d = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      wait_cycles(1);
      n++;
    end
    if (q.size() != 0) begin
      chk("frame_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    wait_cycles(2);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_perr"}, 32'(parity_err), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  initial begin : main
    int            fall;
    int            vc0;
    int            gap;
    logic [DW-1:0] dat;
    logic          sbit;
    logic          prev_break;

    rst = 1'b0;
    d   = 1'b1;
    wait_cycles(3);
    chk_zero("reset");
    rst = 1'b1;
    wait_cycles(5);

    // Clean frame with exact latency.
    send_frame(8'hA5, 1'b0, 1'b1, 0, fall);
    wait_done();
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_perr", 32'(parity_err), 32'd0);
    chk("a5_ferr", 32'(frame_err), 32'd0);
    chk("a5_latency", 32'(last_valid_cyc - fall), 32'd45);

    // Wrong parity bit.
    send_frame(8'h01, 1'b0, 1'b1, 0, fall);
    wait_done();
    chk("p01_data", 32'(data_out), 32'h01);
    chk("p01_perr", 32'(parity_err), 32'd1);
    chk("p01_ferr", 32'(frame_err), 32'd0);

    // Stop bit low, line held low 20 cycles from the stop bit.
    vc0 = valid_count;
    send_frame(8'h3C, 1'b0, 1'b0, 16, fall);
    wait_cycles(4);
    chk("break_idle_busy", 32'(busy), 32'd0);
    wait_done();
    chk("brk_data", 32'(data_out), 32'h3C);
    chk("brk_ferr", 32'(frame_err), 32'd1);
    chk("brk_pulses", 32'(valid_count - vc0), 32'd1);

    // One-cycle glitch in idle.
    vc0 = valid_count;
    drive_bit(1'b0, 1);
    d = 1'b1;
    wait_cycles(4);
    chk("glitch_busy", 32'(busy), 32'd0);
    wait_cycles(10);
    chk("glitch_pulses", 32'(valid_count - vc0), 32'd0);

    // Back-to-back frames.
    vc0 = valid_count;
    send_frame(8'hFF, 1'b0, 1'b1, 0, fall);
    send_frame(8'h00, 1'b0, 1'b1, 0, fall);
    wait_done();
    chk("b2b_pulses", 32'(valid_count - vc0), 32'd2);
    chk("b2b_data", 32'(data_out), 32'h00);
    chk("b2b_perr", 32'(parity_err), 32'd0);

    // Reset during bit 4 of a frame; nothing is queued so any valid is a failure.
    vc0 = valid_count;
    dat = 8'hC3;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(dat[i], CPB);
    d = dat[4];
    wait_cycles(2);
    rst = 1'b0;
    #1;
    chk_zero("abort");
    wait_cycles(3);
    d   = 1'b1;
    rst = 1'b1;
    wait_cycles(4);
    chk("abort_pulses", 32'(valid_count - vc0), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 0, fall);
    wait_done();
    chk("post_rst_data", 32'(data_out), 32'h5A);
    chk("post_rst_perr", 32'(parity_err), 32'd0);
    chk("post_rst_ferr", 32'(frame_err), 32'd0);

    // Random stream: random data, occasional bad parity / low stop, gaps including none.
    prev_break = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (prev_break) gap = $urandom_range(2, 6);
      else gap = $urandom_range(0, 4);
      if (gap > 0) drive_bit(1'b1, gap);
      dat  = DW'($urandom);
      sbit = ($urandom_range(0, 7) != 0);
      send_frame(dat, (^dat) ^ ($urandom_range(0, 3) == 0), sbit,
                 $urandom_range(0, 8), fall);
      prev_break = ~sbit;
    end
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
